data_mem_pipe: RTL
==================

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 SHALL have parameter W, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, number of words; need not be a power of two.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero-fill the array after reset, 0 = skip the fill.
REQ-004 SHALL have localparam AW = max(1, $clog2(DEPTH)), the address width.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  request present this cycle.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 Mem_to_Reg  input  1  1 = result comes from memory, 0 = result comes from ALUResult.
REQ-011 DataAddress  input  AW  word address.
REQ-012 DataIn  input  W  write data.
REQ-013 ALUResult  input  W  bypass value, carried through the pipeline with the request.
REQ-014 DataOut  output  W  result of the accepted request.
REQ-015 out_valid  output  1  DataOut is valid this cycle.
REQ-016 init_done  output  1  high once the zero-fill has finished; stays high until the next reset.
REQ-017 addr_err  output  1  sticky flag: an out-of-range access has occurred.

Function
REQ-018 A request SHALL be accepted on the rising edge where req_valid and req_ready are both high.
REQ-019 req_ready SHALL equal (state == IDLE); the block never back-pressures in IDLE.
REQ-020 An accepted write with DataAddress < DEPTH SHALL update the word at that address on the acceptance edge.
REQ-021 An accepted request SHALL produce exactly one out_valid pulse, one cycle after acceptance (latency 1), for both reads and writes.
REQ-022 DataOut with out_valid SHALL be the stored word (read, Mem_to_Reg=1), the registered ALUResult (Mem_to_Reg=0), or the newly written DataIn (write, Mem_to_Reg=1).
REQ-023 Back-to-back requests SHALL be accepted every cycle; a read immediately following a write to the same address SHALL return the new data.
REQ-024 An access with DataAddress >= DEPTH SHALL be handled as follows: a write is dropped; a read with Mem_to_Reg=1 returns 0; addr_err is set; out_valid still pulses.
REQ-025 When out_valid is low, DataOut SHALL hold its last value.
REQ-026 The FSM SHALL have exactly two states: CLEAR and IDLE.
REQ-027 In CLEAR, a counter clr_addr SHALL write 0 to word clr_addr each cycle and increment from 0 to DEPTH-1; after the write to DEPTH-1 the FSM moves to IDLE.
REQ-028 The zero-fill SHALL take exactly DEPTH cycles; init_done rises on the same edge that the FSM enters IDLE.
REQ-029 With CLEAR_ON_RESET=0, the first state after reset SHALL be IDLE; init_done is high out of reset and array contents are undefined.
REQ-030 Requests presented during CLEAR SHALL NOT be accepted, and SHALL NOT corrupt the array or the counter.

Reset
REQ-031 While reset=0, the block SHALL hold: state=CLEAR (IDLE if CLEAR_ON_RESET=0), clr_addr=0, out_valid=0, DataOut=0, addr_err=0, init_done=CLEAR_ON_RESET?0:1.
REQ-032 Reset SHALL NOT clear the array directly; only the CLEAR state zeroes it.
REQ-033 Reset asserted mid-fill or with a request in flight SHALL abort it: the in-flight out_valid is never produced, and the fill restarts from address 0 after release.

Structure
REQ-034 A shared package data_mem_pkg SHALL hold the state enum (CLEAR, IDLE) and the default W and DEPTH constants.
REQ-035 The storage array SHALL be a sub-module data_mem_core: one synchronous write port and one read port, with no reset on the array.
REQ-036 The FSM, request pipeline register, forwarding, and bounds check SHALL live in data_mem_pipe.

Verification
REQ-037 DEPTH=16; release reset, hold req_valid=1 -> req_ready=0 for exactly 16 cycles; init_done rises at cycle 16; reading every address then returns 0x00.
REQ-038 Write 0xA5 to address 3, then next cycle read address 3 with Mem_to_Reg=1 -> out_valid on consecutive cycles; the second DataOut = 0xA5.
REQ-039 Read with Mem_to_Reg=0, ALUResult=0x3C -> one cycle later DataOut=0x3C, out_valid=1, array unchanged.
REQ-040 DEPTH=10; write 0xFF to address 12, then read address 12 -> read DataOut=0x00, addr_err=1 and stays 1; addresses 0..9 unchanged.
REQ-041 Assert reset at clr_addr=7, release -> fill restarts at 0 and takes the full DEPTH cycles; no out_valid appears during reset or the fill.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory pipeline.
//   state_e   : controller states (CLEAR zero-fills the array, IDLE serves requests)
//   DEF_W     : default data word width
//   DEF_DEPTH : default number of words
package data_mem_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_e;

   localparam int DEF_W     = 8;
   localparam int DEF_DEPTH = 256;

endpackage

// File: rtl/data_mem_core.sv
// Storage array for the data memory pipeline: one synchronous write port and
// one combinational read port. The array has no reset; zeroing is done by the
// controller writing every word.
//   clk     : clock
//   we_i    : write enable (caller guarantees waddr_i < DEPTH when set)
//   waddr_i : write word address
//   wdata_i : write data
//   raddr_i : read word address (result is don't-care when >= DEPTH)
//   rdata_o : word at raddr_i
module data_mem_core
   import data_mem_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_pipe.sv
// Data memory with a one-cycle request pipeline, post-reset zero-fill,
// result forwarding and out-of-range protection.
//   clk         : clock, all state changes on the rising edge
//   reset       : asynchronous, active-low reset
//   req_valid   : request present this cycle
//   req_ready   : request accepted this cycle (high only in IDLE)
//   req_we      : 1 = write, 0 = read
//   Mem_to_Reg  : 1 = result from memory, 0 = result is ALUResult
//   DataAddress : word address
//   DataIn      : write data
//   ALUResult   : bypass value carried with the request
//   DataOut     : result of the accepted request, held between results
//   out_valid   : one-cycle pulse, one cycle after acceptance
//   init_done   : zero-fill finished (high out of reset when fill is disabled)
//   addr_err    : sticky, set by any accepted out-of-range access
module data_mem_pipe
   import data_mem_pkg::*;
#(
   parameter int W              = DEF_W,
   parameter int DEPTH          = DEF_DEPTH,
   parameter int CLEAR_ON_RESET = 1,
   localparam int AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic          Mem_to_Reg,
   input  logic [AW-1:0] DataAddress,
   input  logic [W-1:0]  DataIn,
   input  logic [W-1:0]  ALUResult,
   output logic [W-1:0]  DataOut,
   output logic          out_valid,
   output logic          init_done,
   output logic          addr_err
);

   localparam state_e        RST_STATE     = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
   localparam logic          RST_INIT_DONE = (CLEAR_ON_RESET == 0) ? 1'b1 : 1'b0;
   // One extra bit so DEPTH itself is representable when DEPTH == 2**AW.
   localparam logic [AW:0]   DEPTH_C       = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR     = AW'(DEPTH - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  dout_q, dout_d;
   logic          addr_err_q, addr_err_d;
   logic          init_done_q, init_done_d;

   logic          clearing;
   logic          accept;
   logic          in_range;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [W-1:0]  mem_wdata;
   logic [W-1:0]  mem_rdata;
   logic [W-1:0]  mem_res;
   logic [W-1:0]  result;

   assign clearing  = (state_q == CLEAR);
   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid && req_ready;
   assign in_range  = ({1'b0, DataAddress} < DEPTH_C);

   // The fill owns the write port while clearing; requests are not accepted
   // then, so they can never reach the array or the counter.
   assign mem_we    = clearing || (accept && req_we && in_range);
   assign mem_waddr = clearing ? clr_addr_q : DataAddress;
   assign mem_wdata = clearing ? '0 : DataIn;

   data_mem_core #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_core (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (mem_wdata),
      .raddr_i (DataAddress),
      .rdata_o (mem_rdata)
   );

   // A write returns the data it stores (the array only updates on the same
   // edge). Anything out of range reads as zero, including a dropped write.
   always_comb begin
      mem_res = '0;
      if (in_range) begin
         mem_res = req_we ? DataIn : mem_rdata;
      end
      result = Mem_to_Reg ? mem_res : ALUResult;
   end

   always_comb begin
      state_d     = state_q;
      clr_addr_d  = clr_addr_q;
      init_done_d = init_done_q;
      out_valid_d = accept;
      dout_d      = accept ? result : dout_q;
      addr_err_d  = addr_err_q || (accept && !in_range);
      case (state_q)
         CLEAR: begin
            if (clr_addr_q == LAST_ADDR) begin
               state_d     = IDLE;
               clr_addr_d  = '0;
               init_done_d = 1'b1;
            end else begin
               clr_addr_d  = clr_addr_q + AW'(1);
            end
         end
         IDLE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = RST_STATE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= RST_STATE;
         clr_addr_q  <= '0;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         addr_err_q  <= 1'b0;
         init_done_q <= RST_INIT_DONE;
      end else begin
         state_q     <= state_d;
         clr_addr_q  <= clr_addr_d;
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         addr_err_q  <= addr_err_d;
         init_done_q <= init_done_d;
      end
   end

   assign DataOut   = dout_q;
   assign out_valid = out_valid_q;
   assign init_done = init_done_q;
   assign addr_err  = addr_err_q;

endmodule
